// File: rtl/wb_switch_n_if.sv
// Wishbone classic bus bundle for wb_switch_n. PORTS sets the number of cyc/stb/ack
// lanes and read-data slices: 1 on the master side, NUM_SLAVES on the slave side.
interface wb_switch_n_if #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH/8,
  parameter int PORTS        = 1
);
  logic [ADDR_WIDTH-1:0]       adr;
  logic [DATA_WIDTH-1:0]       dat_w;
  logic [PORTS*DATA_WIDTH-1:0] dat_r;
  logic                        we;
  logic [SELECT_WIDTH-1:0]     sel;
  logic [PORTS-1:0]            cyc;
  logic [PORTS-1:0]            stb;
  logic [PORTS-1:0]            ack;

  modport master (
    output adr, dat_w, we, sel, cyc, stb,
    input  dat_r, ack
  );

  modport slave (
    input  adr, dat_w, we, sel, cyc, stb,
    output dat_r, ack
  );
endinterface

// File: rtl/wb_switch_n.sv
// 1-master / NUM_SLAVES-slave Wishbone classic switch, all slave-side signals registered.
// Optional per-access timeout enabled by defining WB_SWITCH_TIMEOUT_EN.
module wb_switch_n #(
  parameter int NUM_SLAVES   = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH/8,
  parameter logic [ADDR_WIDTH-1:0]            ADDR_MASK = 32'hFFFFF000,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] BASE_ADDR =
    {32'h30003000, 32'h30002000, 32'h30001000, 32'h30000000},
  parameter logic [DATA_WIDTH-1:0]            MISS_DATA = 32'hDEADBEEF
`ifdef WB_SWITCH_TIMEOUT_EN
  ,
  parameter int                    TIMEOUT_CYCLES = 255,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA   = 32'hBADC0FFE
`endif
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n_i,
  wb_switch_n_if.slave  wbm,
  wb_switch_n_if.master wbs,
  output logic          miss_o,
  output logic          timeout_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state;
  logic [NUM_SLAVES-1:0]   hit_oh;
  logic [NUM_SLAVES-1:0]   cyc_q;
  logic [DATA_WIDTH-1:0]   slv_rdata;
  logic                    slv_ack;

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    hit_oh = '0;
    for (int i = NUM_SLAVES-1; i >= 0; i--) begin
      if ((wbm.adr & ADDR_MASK) == (BASE_ADDR[i*ADDR_WIDTH +: ADDR_WIDTH] & ADDR_MASK)) begin
        hit_oh    = '0;
        hit_oh[i] = 1'b1;
      end
    end
  end

  // cyc_q is one-hot while BUSY, so it doubles as the read-data and ack select.
  always_comb begin
    slv_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (cyc_q[i]) slv_rdata = slv_rdata | wbs.dat_r[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign slv_ack = |(wbs.ack & cyc_q);
  assign wbs.cyc = cyc_q;
  assign wbs.stb = cyc_q;

`ifdef WB_SWITCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_hit;
  assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state     <= IDLE;
      cyc_q     <= '0;
      wbs.adr   <= '0;
      wbs.dat_w <= '0;
      wbs.we    <= 1'b0;
      wbs.sel   <= '0;
      wbm.dat_r <= '0;
      wbm.ack   <= '0;
      miss_o    <= 1'b0;
`ifdef WB_SWITCH_TIMEOUT_EN
      timeout_o <= 1'b0;
      tmo_cnt   <= '0;
`endif
    end else begin
      wbm.ack <= '0;
      miss_o  <= 1'b0;
`ifdef WB_SWITCH_TIMEOUT_EN
      timeout_o <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (wbm.cyc[0] && wbm.stb[0]) begin
            wbs.adr   <= wbm.adr;
            wbs.dat_w <= wbm.dat_w;
            wbs.we    <= wbm.we;
            wbs.sel   <= wbm.sel;
            if (|hit_oh) begin
              cyc_q <= hit_oh;
              state <= BUSY;
`ifdef WB_SWITCH_TIMEOUT_EN
              tmo_cnt <= '0;
`endif
            end else begin
              // Unmapped: answer locally; a miss write is simply dropped.
              wbm.dat_r <= MISS_DATA;
              wbm.ack   <= '1;
              miss_o    <= 1'b1;
              state     <= DONE;
            end
          end
        end
        BUSY: begin
          if (!wbm.cyc[0]) begin
            cyc_q <= '0;
            state <= IDLE;
          end else if (slv_ack) begin
            cyc_q     <= '0;
            wbm.dat_r <= slv_rdata;
            wbm.ack   <= '1;
            state     <= DONE;
          end
`ifdef WB_SWITCH_TIMEOUT_EN
          else if (tmo_hit) begin
            cyc_q     <= '0;
            wbm.dat_r <= TIMEOUT_DATA;
            wbm.ack   <= '1;
            timeout_o <= 1'b1;
            state     <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_switch_n.sv
// Directed bench for wb_switch_n: decode, read/write, miss, spurious ack,
// master abort, async reset and (when WB_SWITCH_TIMEOUT_EN is defined) timeout.
module tb_wb_switch_n;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic miss, tmo;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  wb_switch_n_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SELECT_WIDTH(4), .PORTS(1)) m_if ();
  wb_switch_n_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SELECT_WIDTH(4), .PORTS(4)) s_if ();

  wb_switch_n dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .wbm        (m_if.slave),
    .wbs        (s_if.master),
    .miss_o     (miss),
    .timeout_o  (tmo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [31:0] a, input logic w, input logic [31:0] d);
    m_if.adr   = a;
    m_if.we    = w;
    m_if.dat_w = d;
    m_if.sel   = 4'hF;
    m_if.cyc   = 1'b1;
    m_if.stb   = 1'b1;
  endtask

  task automatic idle_m();
    m_if.cyc = 1'b0;
    m_if.stb = 1'b0;
    m_if.we  = 1'b0;
  endtask

  initial begin
    int k;
    int acks;
    m_if.adr = '0; m_if.dat_w = '0; m_if.we = 1'b0; m_if.sel = '0;
    m_if.cyc = '0; m_if.stb = '0;
    s_if.dat_r = '0; s_if.ack = '0;

    // Reset
    #2 rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_ack",  m_if.ack,   0);
    chk("rst_dat",  m_if.dat_r, 0);
    chk("rst_cyc",  s_if.cyc,   0);
    chk("rst_adr",  s_if.adr,   0);
    chk("rst_miss", miss,       0);
    chk("rst_tmo",  tmo,        0);
    rst_n = 1'b1;
    tick();

    // 1: read slave 2, slave acks in its first strobe cycle
    req(32'h30002004, 1'b0, 32'h0);
    tick();
    chk("rd_stb",  s_if.stb, 4'b0100);
    chk("rd_cyc",  s_if.cyc, 4'b0100);
    chk("rd_adr",  s_if.adr, 32'h30002004);
    chk("rd_ack0", m_if.ack, 0);
    s_if.ack   = 4'b0100;
    s_if.dat_r = {32'h33333333, 32'h12345678, 32'h11111111, 32'h00000000};
    tick();
    chk("rd_stb_drop", s_if.stb, 0);
    chk("rd_ack",      m_if.ack, 1);
    chk("rd_dat",      m_if.dat_r, 32'h12345678);
    chk("rd_miss",     miss, 0);
    s_if.ack = '0;
    idle_m();
    tick();
    chk("rd_ack_1cyc", m_if.ack, 0);
    chk("rd_dat_hold", m_if.dat_r, 32'h12345678);

    // 2: write slave 1
    req(32'h30001010, 1'b1, 32'hA5A5A5A5);
    tick();
    chk("wr_adr", s_if.adr,   32'h30001010);
    chk("wr_dat", s_if.dat_w, 32'hA5A5A5A5);
    chk("wr_sel", s_if.sel,   4'hF);
    chk("wr_we",  s_if.we,    1);
    chk("wr_stb", s_if.stb,   4'b0010);
    s_if.ack = 4'b0010;
    tick();
    chk("wr_ack", m_if.ack, 1);
    chk("wr_cyc", s_if.cyc, 0);
    s_if.ack = '0;
    idle_m();
    tick();
    chk("wr_ack_1cyc", m_if.ack, 0);

    // 3: unmapped read answered locally next cycle
    req(32'h40000000, 1'b0, 32'h0);
    tick();
    chk("miss_ack", m_if.ack,   1);
    chk("miss_dat", m_if.dat_r, 32'hDEADBEEF);
    chk("miss_flg", miss,       1);
    chk("miss_cyc", s_if.cyc,   0);
    idle_m();
    tick();
    chk("miss_ack_1cyc", m_if.ack, 0);
    chk("miss_flg_1cyc", miss,     0);

    // acks while idle are ignored
    s_if.ack = 4'hF;
    tick();
    tick();
    chk("idle_ack_ign", m_if.ack, 0);
    s_if.ack = '0;

    // 5: spurious ack from slave 0 while slave 1 is busy
    req(32'h30001000, 1'b0, 32'h0);
    tick();
    chk("sp_stb", s_if.stb, 4'b0010);
    s_if.ack = 4'b0001;
    tick();
    chk("sp_ign_ack", m_if.ack, 0);
    chk("sp_ign_cyc", s_if.cyc, 4'b0010);
    s_if.ack   = 4'b0010;
    s_if.dat_r = {32'h33333333, 32'h22222222, 32'hCAFEF00D, 32'h11111111};
    tick();
    chk("sp_ack", m_if.ack,   1);
    chk("sp_dat", m_if.dat_r, 32'hCAFEF00D);
    s_if.ack = '0;
    idle_m();
    tick();

    // 6a: master abort mid-BUSY
    req(32'h30000008, 1'b0, 32'h0);
    tick();
    chk("ab_cyc", s_if.cyc, 4'b0001);
    idle_m();
    tick();
    chk("ab_cyc_drop", s_if.cyc, 0);
    chk("ab_no_ack",   m_if.ack, 0);
    tick();
    chk("ab_no_ack2",  m_if.ack, 0);
    req(32'h30000008, 1'b0, 32'h0);
    tick();
    s_if.ack   = 4'b0001;
    s_if.dat_r = {32'h0, 32'h0, 32'h0, 32'h0BADF00D};
    tick();
    chk("ab_next_ack", m_if.ack,   1);
    chk("ab_next_dat", m_if.dat_r, 32'h0BADF00D);
    s_if.ack = '0;
    idle_m();
    tick();

    // 6b: asynchronous reset pulse mid-BUSY
    req(32'h30003000, 1'b0, 32'h0);
    tick();
    chk("rs_cyc", s_if.cyc, 4'b1000);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_async_cyc", s_if.cyc, 0);
    chk("rs_async_ack", m_if.ack, 0);
    idle_m();
    tick();
    rst_n = 1'b1;
    tick();
    req(32'h30003000, 1'b0, 32'h0);
    tick();
    chk("rs_next_stb", s_if.stb, 4'b1000);
    s_if.ack   = 4'b1000;
    s_if.dat_r = {32'h76543210, 32'h0, 32'h0, 32'h0};
    tick();
    chk("rs_next_ack", m_if.ack,   1);
    chk("rs_next_dat", m_if.dat_r, 32'h76543210);
    s_if.ack = '0;
    idle_m();
    tick();

    // 4: slave 3 never acks
    req(32'h30003004, 1'b0, 32'h0);
    tick();
`ifdef WB_SWITCH_TIMEOUT_EN
    k = 1;
    while (m_if.ack == 1'b0 && k < 400) begin
      tick();
      k++;
    end
    chk("tmo_lat",  k,          256);
    chk("tmo_ack",  m_if.ack,   1);
    chk("tmo_dat",  m_if.dat_r, 32'hBADC0FFE);
    chk("tmo_flg",  tmo,        1);
    chk("tmo_cyc",  s_if.cyc,   0);
    idle_m();
    tick();
    chk("tmo_flg_1cyc", tmo, 0);
`else
    acks = 0;
    repeat (300) begin
      tick();
      if (m_if.ack != 1'b0) acks++;
    end
    chk("hang_no_ack", acks,     0);
    chk("hang_cyc",    s_if.cyc, 4'b1000);
    chk("hang_tmo",    tmo,      0);
    idle_m();
    tick();
    chk("hang_abort",  s_if.cyc, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
